reg_pipe: RTL and testbench

Parametrised elastic register pipeline: a WIDTH-bit data path delayed through DEPTH register stages, with per-stage valid bits and valid/ready back-pressure. Successor to the fixed 8-bit single-stage register bank; used wherever a datapath needs retiming stages that can stall without dropping or duplicating words. Sits between producer and consumer blocks on the single system clock.

---
 rtl/reg_pipe.sv | 87 ++++++++
 tb/tb_reg_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// reg_pipe: elastic WIDTH-bit register pipeline of DEPTH stages with valid/ready.
// Optional occupancy output enabled by defining REG_PIPE_OCC_EN.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of all stage valid bits
//   in_valid/in_data/in_ready     producer handshake
//   out_valid/out_data/out_ready  consumer handshake
//   occupancy       count of valid stages (REG_PIPE_OCC_EN only)
module reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];

    // A stage may load when it is empty or its successor moves on;
    // computed from the consumer end back towards the producer.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = !v_q[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = !v_q[k] | adv[k+1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv[0]) begin
            v_d[0] = in_valid;
            if (in_valid) d_d[0] = in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) d_d[k] = d_q[k-1];
            end
        end
        // Data registers keep their contents; only occupancy is dropped.
        if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(v_q[k]);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: scoreboard bench for reg_pipe (WIDTH=8, DEPTH=3).
// Occupancy checks compile in when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
`ifdef REG_PIPE_OCC_EN
    logic [$clog2(D+1)-1:0] occupancy;
`endif

    reg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef REG_PIPE_OCC_EN
        ,
        .occupancy (occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    logic [W-1:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic occ_chk(input string tag, input int exp);
`ifdef REG_PIPE_OCC_EN
        chk(tag, 32'(occupancy), 32'(exp));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfers are sampled mid-cycle, before the edge that performs them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) chk("spurious", 32'(out_data), 32'hFFFF);
                    else chk("data", 32'(out_data), 32'(sb_q.pop_front()));
                end
                if (in_valid && in_ready) sb_q.push_back(in_data);
            end
        end
    end

    int acc;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_ir", 32'(in_ready), 1);
        occ_chk("rst_occ", 0);
        #10 rst_n = 1'b1;
        step();

        // latency and throughput
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        chk("lat_n0", 32'(out_valid), 0);
        in_data = 8'h22;
        step();
        chk("lat_n1", 32'(out_valid), 0);
        in_data = 8'h33;
        step();
        chk("lat_n2", 32'(out_valid), 1);
        chk("lat_d", 32'(out_data), 32'h11);
        in_valid = 1'b0;
        step();
        chk("tp_1", 32'(out_valid), 1);
        step();
        chk("tp_2", 32'(out_valid), 1);
        step();
        chk("tp_end", 32'(out_valid), 0);

        // fill until back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h40 + acc);
            if (in_ready) acc++;
            step();
        end
        chk("fill_cnt", 32'(acc), D);
        chk("full_ir", 32'(in_ready), 0);
        occ_chk("full_occ", D);

        // full with simultaneous in and out
        out_ready = 1'b1;
        in_data = 8'hA5;
        #1;
        chk("fio_ir", 32'(in_ready), 1);
        step();
        occ_chk("fio_occ1", D);
        step();
        occ_chk("fio_occ2", D);
        in_valid = 1'b0;
        for (int j = D - 1; j >= 0; j--) begin
            step();
            occ_chk("drain_occ", j);
        end
        chk("drain_ov", 32'(out_valid), 0);

        // bubble collapse under stall
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h01;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_data = 8'h02;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_ov", 32'(out_valid), 1);
        chk("bub_od", 32'(out_data), 32'h01);
        occ_chk("bub_occ", 2);
        out_ready = 1'b1;
        repeat (3) step();
        chk("bub_end", 32'(out_valid), 0);

        // flush with a concurrent input
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        in_data = 8'h66;
        step();
        in_data = 8'h7E;
        flush = 1'b1;
        #1;
        chk("fl_ir", 32'(in_ready), 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov", 32'(out_valid), 0);
        occ_chk("fl_occ", 0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("fl_after", 32'(out_valid), 0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h91;
        step();
        in_data = 8'h92;
        step();
        in_data = 8'h93;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("ar_pre", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_ov", 32'(out_valid), 0);
        chk("ar_od", 32'(out_data), 0);
        chk("ar_ir", 32'(in_ready), 1);
        occ_chk("ar_occ", 0);
        sb_q.delete();
        rst_n = 1'b1;
        repeat (4) step();
        chk("ar_stale", 32'(out_valid), 0);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (D + 2) step();
        chk("rnd_ov", 32'(out_valid), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
